// File: rtl/bts_pkg.sv
// ---------------------------------------------------------------------------
// bts_pkg
// Shared definitions for the branch/trap sequencer and its condition
// evaluator: the 4-bit SPARC icc condition encodings, the IR op field
// values that select a branch or a trap, and the sequencer state enum.
// No ports (package).
// ---------------------------------------------------------------------------
package bts_pkg;

   // Condition field encodings, IR[28:25]. The upper half is the logical
   // inverse of the lower half entry with the same low three bits.
   localparam logic [3:0] COND_N   = 4'h0;
   localparam logic [3:0] COND_E   = 4'h1;
   localparam logic [3:0] COND_LE  = 4'h2;
   localparam logic [3:0] COND_L   = 4'h3;
   localparam logic [3:0] COND_LEU = 4'h4;
   localparam logic [3:0] COND_CS  = 4'h5;
   localparam logic [3:0] COND_NEG = 4'h6;
   localparam logic [3:0] COND_VS  = 4'h7;
   localparam logic [3:0] COND_A   = 4'h8;
   localparam logic [3:0] COND_NE  = 4'h9;
   localparam logic [3:0] COND_G   = 4'hA;
   localparam logic [3:0] COND_GE  = 4'hB;
   localparam logic [3:0] COND_GU  = 4'hC;
   localparam logic [3:0] COND_CC  = 4'hD;
   localparam logic [3:0] COND_POS = 4'hE;
   localparam logic [3:0] COND_VC  = 4'hF;

   // IR[31:30] op values handled here; 01 and 11 are reported as bad_op.
   localparam logic [1:0] OP_BR   = 2'b00;
   localparam logic [1:0] OP_TRAP = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_CC = 2'd1,
      RESOLVE = 2'd2,
      TRAP    = 2'd3
   } bts_state_e;

endpackage

// File: rtl/branch_trap_sequencer_cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational evaluation of a SPARC Bicc/Ticc condition against
// the integer condition codes. Kept separate so decode can reuse it.
// Ports:
//   cond       in  4  condition field IR[28:25]
//   C,N,V,Z    in  1  integer condition codes
//   cond_true  out 1  condition holds for the given flags
// ---------------------------------------------------------------------------
module cond_eval
   import bts_pkg::*;
(
   input  logic [3:0] cond,
   input  logic       C,
   input  logic       N,
   input  logic       V,
   input  logic       Z,
   output logic       cond_true
);

   // Full decode of all sixteen conditions; the upper eight are the
   // complements of the lower eight (a/n, ne/e, g/le, ...).
   always_comb begin
      cond_true = 1'b0;
      case (cond)
         COND_N:   cond_true = 1'b0;
         COND_E:   cond_true = Z;
         COND_LE:  cond_true = Z | (N ^ V);
         COND_L:   cond_true = N ^ V;
         COND_LEU: cond_true = C | Z;
         COND_CS:  cond_true = C;
         COND_NEG: cond_true = N;
         COND_VS:  cond_true = V;
         COND_A:   cond_true = 1'b1;
         COND_NE:  cond_true = ~Z;
         COND_G:   cond_true = ~(Z | (N ^ V));
         COND_GE:  cond_true = ~(N ^ V);
         COND_GU:  cond_true = ~(C | Z);
         COND_CC:  cond_true = ~C;
         COND_POS: cond_true = ~N;
         COND_VC:  cond_true = ~V;
         default:  cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_trap_sequencer.sv
// ---------------------------------------------------------------------------
// branch_trap_sequencer
// Accepts one decoded Bicc/Ticc at a time, waits for the icc flags to stop
// changing, evaluates the condition, and then either reports a branch
// result (taken / delay-slot annul) or raises a trap request that is held
// until the trap unit acknowledges it.
//
// Optional feature: define BTS_STATS_EN to add saturating statistics
// counters br_taken_cnt and trap_cnt (STAT_W bits each).
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   issue_valid/ready  issue handshake; ready only while IDLE
//   ir31_25[6:0]    op[6:5], annul bit [4], cond[3:0]
//   trap_num[6:0]   software trap number
//   cc_busy         icc still pending from an in-flight instruction
//   C,N,V,Z         integer condition codes
//   flush           abandon the current instruction
//   res_valid       1-cycle branch result strobe
//   br_taken        branch redirect, qualified by res_valid
//   annul_slot      delay-slot squash, qualified by res_valid
//   trap_req/ack    trap handshake, req held until ack
//   trap_tt[7:0]    trap type TT_BASE + trap_num, stable while trap_req
//   bad_op          1-cycle strobe for an op that is neither branch nor trap
//   br_taken_cnt, trap_cnt  (BTS_STATS_EN only) event counters
// ---------------------------------------------------------------------------
module branch_trap_sequencer
   import bts_pkg::*;
#(
   parameter logic [7:0] TT_BASE = 8'h80,
   parameter int         STAT_W  = 16
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [6:0]        ir31_25,
   input  logic [6:0]        trap_num,
   input  logic              cc_busy,
   input  logic              C,
   input  logic              N,
   input  logic              V,
   input  logic              Z,
   input  logic              flush,
   output logic              res_valid,
   output logic              br_taken,
   output logic              annul_slot,
   output logic              trap_req,
   input  logic              trap_ack,
   output logic [7:0]        trap_tt,
   output logic              bad_op
`ifdef BTS_STATS_EN
   ,
   output logic [STAT_W-1:0] br_taken_cnt,
   output logic [STAT_W-1:0] trap_cnt
`endif
);

   bts_state_e state_q, state_d;
   logic [6:0] ir_q, ir_d;
   logic [6:0] tnum_q, tnum_d;
   logic [3:0] flags_q, flags_d;
   logic       issue_ready_q, issue_ready_d;
   logic       res_valid_q, res_valid_d;
   logic       br_taken_q, br_taken_d;
   logic       annul_q, annul_d;
   logic       trap_req_q, trap_req_d;
   logic [7:0] trap_tt_q, trap_tt_d;
   logic       bad_op_q, bad_op_d;
   logic       cond_true;

   // The condition is always evaluated on the latched IR and flags, so the
   // live C/N/V/Z inputs may move freely once they have been captured.
   cond_eval u_cond_eval (
      .cond      (ir_q[3:0]),
      .C         (flags_q[3]),
      .N         (flags_q[2]),
      .V         (flags_q[1]),
      .Z         (flags_q[0]),
      .cond_true (cond_true)
   );

   // Next-state and next-output logic. Every output is registered, so the
   // result strobes appear on the edge that leaves RESOLVE. Flush is
   // applied last so it overrides an ack, a new issue, or a pending result.
   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      tnum_d      = tnum_q;
      flags_d     = flags_q;
      res_valid_d = 1'b0;
      br_taken_d  = 1'b0;
      annul_d     = 1'b0;
      bad_op_d    = 1'b0;
      trap_req_d  = trap_req_q;
      trap_tt_d   = trap_tt_q;

      case (state_q)
         IDLE: begin
            if (issue_valid) begin
               ir_d   = ir31_25;
               tnum_d = trap_num;
               if (!cc_busy) begin
                  flags_d = {C, N, V, Z};
                  state_d = RESOLVE;
               end else begin
                  state_d = WAIT_CC;
               end
            end
         end
         WAIT_CC: begin
            if (!cc_busy) begin
               flags_d = {C, N, V, Z};
               state_d = RESOLVE;
            end
         end
         RESOLVE: begin
            state_d = IDLE;
            case (ir_q[6:5])
               OP_BR: begin
                  res_valid_d = 1'b1;
                  br_taken_d  = cond_true;
                  // BA,a annuls its slot even though it is taken.
                  annul_d     = ir_q[4] & (~cond_true | (ir_q[3:0] == COND_A));
               end
               OP_TRAP: begin
                  if (cond_true) begin
                     trap_req_d = 1'b1;
                     trap_tt_d  = TT_BASE + {1'b0, tnum_q};
                     state_d    = TRAP;
                  end
               end
               default: bad_op_d = 1'b1;
            endcase
         end
         TRAP: begin
            if (trap_ack) begin
               trap_req_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (flush) begin
         state_d     = IDLE;
         res_valid_d = 1'b0;
         br_taken_d  = 1'b0;
         annul_d     = 1'b0;
         trap_req_d  = 1'b0;
         bad_op_d    = 1'b0;
      end

      // Ready is registered from the next state, so there is no path from
      // issue_valid to issue_ready within a cycle.
      issue_ready_d = (state_d == IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         ir_q          <= '0;
         tnum_q        <= '0;
         flags_q       <= '0;
         issue_ready_q <= 1'b1;
         res_valid_q   <= 1'b0;
         br_taken_q    <= 1'b0;
         annul_q       <= 1'b0;
         trap_req_q    <= 1'b0;
         trap_tt_q     <= 8'h00;
         bad_op_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         ir_q          <= ir_d;
         tnum_q        <= tnum_d;
         flags_q       <= flags_d;
         issue_ready_q <= issue_ready_d;
         res_valid_q   <= res_valid_d;
         br_taken_q    <= br_taken_d;
         annul_q       <= annul_d;
         trap_req_q    <= trap_req_d;
         trap_tt_q     <= trap_tt_d;
         bad_op_q      <= bad_op_d;
      end
   end

   assign issue_ready = issue_ready_q;
   assign res_valid   = res_valid_q;
   assign br_taken    = br_taken_q;
   assign annul_slot  = annul_q;
   assign trap_req    = trap_req_q;
   assign trap_tt     = trap_tt_q;
   assign bad_op      = bad_op_q;

`ifdef BTS_STATS_EN
   logic [STAT_W-1:0] br_taken_cnt_q, br_taken_cnt_d;
   logic [STAT_W-1:0] trap_cnt_q, trap_cnt_d;

   // Saturating event counters; they are only cleared by reset, never by
   // flush, so they survive pipeline recoveries.
   always_comb begin
      br_taken_cnt_d = br_taken_cnt_q;
      trap_cnt_d     = trap_cnt_q;
      if (res_valid_q && br_taken_q && (br_taken_cnt_q != '1)) begin
         br_taken_cnt_d = br_taken_cnt_q + 1'b1;
      end
      if (trap_req_q && trap_ack && (trap_cnt_q != '1)) begin
         trap_cnt_d = trap_cnt_q + 1'b1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         br_taken_cnt_q <= '0;
         trap_cnt_q     <= '0;
      end else begin
         br_taken_cnt_q <= br_taken_cnt_d;
         trap_cnt_q     <= trap_cnt_d;
      end
   end

   assign br_taken_cnt = br_taken_cnt_q;
   assign trap_cnt     = trap_cnt_q;
`else
   // STAT_W only sizes the optional counters; tie it off here.
   logic unused_stat_w;
   assign unused_stat_w = ^STAT_W;
`endif

endmodule

// File: tb/tb_branch_trap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_branch_trap_sequencer
// Self-checking bench for branch_trap_sequencer. Branch results expected by
// each scenario are pushed to a scoreboard queue when the instruction is
// accepted and popped when res_valid is seen. Inputs change #1 after the
// rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_branch_trap_sequencer;

   typedef struct packed {
      logic taken;
      logic annul;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       issue_valid;
   logic       issue_ready;
   logic [6:0] ir31_25;
   logic [6:0] trap_num;
   logic       cc_busy;
   logic       C, N, V, Z;
   logic       flush;
   logic       res_valid;
   logic       br_taken;
   logic       annul_slot;
   logic       trap_req;
   logic       trap_ack;
   logic [7:0] trap_tt;
   logic       bad_op;
`ifdef BTS_STATS_EN
   logic [15:0] br_taken_cnt;
   logic [15:0] trap_cnt;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   branch_trap_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .ir31_25     (ir31_25),
      .trap_num    (trap_num),
      .cc_busy     (cc_busy),
      .C           (C),
      .N           (N),
      .V           (V),
      .Z           (Z),
      .flush       (flush),
      .res_valid   (res_valid),
      .br_taken    (br_taken),
      .annul_slot  (annul_slot),
      .trap_req    (trap_req),
      .trap_ack    (trap_ack),
      .trap_tt     (trap_tt),
      .bad_op      (bad_op)
`ifdef BTS_STATS_EN
      ,
      .br_taken_cnt(br_taken_cnt),
      .trap_cnt    (trap_cnt)
`endif
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference condition table written straight from the SPARC icc rules.
   function automatic logic golden(input logic [3:0] cond, input logic [3:0] f);
      logic c, n, v, z;
      {c, n, v, z} = f;
      case (cond)
         4'h0:    return 1'b0;
         4'h1:    return z;
         4'h2:    return z | (n ^ v);
         4'h3:    return n ^ v;
         4'h4:    return c | z;
         4'h5:    return c;
         4'h6:    return n;
         4'h7:    return v;
         4'h8:    return 1'b1;
         4'h9:    return !z;
         4'hA:    return !(z | (n ^ v));
         4'hB:    return !(n ^ v);
         4'hC:    return !(c | z);
         4'hD:    return !c;
         4'hE:    return !n;
         default: return !v;
      endcase
   endfunction

   function automatic exp_t expect_br(input logic [6:0] ir, input logic [3:0] f);
      exp_t e;
      e.taken = golden(ir[3:0], f);
      e.annul = ir[4] & (!e.taken | (ir[3:0] == 4'h8));
      return e;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_flags(input logic [3:0] f);
      {C, N, V, Z} = f;
   endtask

   // Offer one instruction for exactly one edge; the caller guarantees IDLE.
   task automatic drive_issue(input logic [6:0] ir, input logic [6:0] tn, input logic busy);
      issue_valid = 1'b1;
      ir31_25     = ir;
      trap_num    = tn;
      cc_busy     = busy;
      tick;
      issue_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset       = 1'b1;
      issue_valid = 1'b0;
      ir31_25     = '0;
      trap_num    = '0;
      cc_busy     = 1'b0;
      flush       = 1'b0;
      trap_ack    = 1'b0;
      set_flags(4'h0);
      tick;
      tick;
      reset = 1'b0;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_issue_ready got=%b exp=1", issue_ready); end
      checks++; if (trap_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_trap_req got=%b exp=0", trap_req); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid got=%b exp=0", res_valid); end
      checks++; if (trap_tt !== 8'h00) begin errors++; $display("[TB] FAIL reset_trap_tt got=%h exp=00", trap_tt); end
      checks++; if (bad_op !== 1'b0) begin errors++; $display("[TB] FAIL reset_bad_op got=%b exp=0", bad_op); end
   endtask

   // Every condition against every flag pattern; flags are scrambled right
   // after acceptance so only the latched copy can give the right answer.
   task automatic test_all_conds;
      exp_t e;
      for (int cnd = 0; cnd < 16; cnd++) begin
         for (int f = 0; f < 16; f++) begin
            set_flags(f[3:0]);
            sb.push_back(expect_br({3'b000, cnd[3:0]}, f[3:0]));
            drive_issue({3'b000, cnd[3:0]}, 7'h00, 1'b0);
            set_flags(~f[3:0]);
            checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL cond_early cond=%h flags=%h got res_valid=%b exp=0", cnd, f, res_valid); end
            tick;
            checks++;
            if (res_valid !== 1'b1) begin
               errors++;
               $display("[TB] FAIL cond_latency cond=%h flags=%h got res_valid=%b exp=1", cnd, f, res_valid);
               void'(sb.pop_front());
            end else begin
               e = sb.pop_front();
               checks++; if (br_taken !== e.taken) begin errors++; $display("[TB] FAIL cond_taken cond=%h flags=%h got=%b exp=%b", cnd, f, br_taken, e.taken); end
               checks++; if (annul_slot !== e.annul) begin errors++; $display("[TB] FAIL cond_annul cond=%h flags=%h got=%b exp=%b", cnd, f, annul_slot, e.annul); end
            end
         end
      end
   endtask

   task automatic test_annul;
      logic [6:0] irs [4] = '{7'b0011001, 7'b0011000, 7'b0010001, 7'b0010000};
      exp_t       exps[4] = '{'{1'b0, 1'b1}, '{1'b1, 1'b1}, '{1'b1, 1'b0}, '{1'b0, 1'b1}};
      exp_t       e;
      set_flags(4'b0001);
      for (int i = 0; i < 4; i++) begin
         sb.push_back(exps[i]);
         drive_issue(irs[i], 7'h00, 1'b0);
         tick;
         checks++;
         if (res_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL annul_valid case=%0d got=%b exp=1", i, res_valid);
            void'(sb.pop_front());
         end else begin
            e = sb.pop_front();
            checks++; if (br_taken !== e.taken) begin errors++; $display("[TB] FAIL annul_taken case=%0d got=%b exp=%b", i, br_taken, e.taken); end
            checks++; if (annul_slot !== e.annul) begin errors++; $display("[TB] FAIL annul_slot case=%0d got=%b exp=%b", i, annul_slot, e.annul); end
         end
      end
   endtask

   task automatic test_cc_busy;
      exp_t e;
      set_flags(4'b0000);
      drive_issue(7'b0000011, 7'h00, 1'b1);
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("[TB] FAIL busy_ready_accept got=%b exp=0", issue_ready); end
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++; if (issue_ready !== 1'b0) begin errors++; $display("[TB] FAIL busy_ready_wait cyc=%0d got=%b exp=0", i, issue_ready); end
         checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL busy_res_wait cyc=%0d got=%b exp=0", i, res_valid); end
      end
      cc_busy = 1'b0;
      set_flags(4'b0100);
      sb.push_back(expect_br(7'b0000011, 4'b0100));
      tick;
      set_flags(4'b0000);
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("[TB] FAIL busy_ready_resolve got=%b exp=0", issue_ready); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL busy_res_resolve got=%b exp=0", res_valid); end
      tick;
      checks++;
      if (res_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL busy_res_valid got=%b exp=1", res_valid);
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         checks++; if (br_taken !== e.taken) begin errors++; $display("[TB] FAIL busy_taken got=%b exp=%b", br_taken, e.taken); end
      end
   endtask

   task automatic test_trap;
      set_flags(4'b0001);
      drive_issue(7'b1000001, 7'h05, 1'b0);
      checks++; if (trap_req !== 1'b0) begin errors++; $display("[TB] FAIL trap_early got=%b exp=0", trap_req); end
      for (int i = 0; i < 5; i++) begin
         tick;
         checks++; if (trap_req !== 1'b1) begin errors++; $display("[TB] FAIL trap_hold cyc=%0d got=%b exp=1", i, trap_req); end
         checks++; if (trap_tt !== 8'h85) begin errors++; $display("[TB] FAIL trap_tt cyc=%0d got=%h exp=85", i, trap_tt); end
      end
      trap_ack = 1'b1;
      tick;
      trap_ack = 1'b0;
      checks++; if (trap_req !== 1'b0) begin errors++; $display("[TB] FAIL trap_ack_drop got=%b exp=0", trap_req); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL trap_ack_ready got=%b exp=1", issue_ready); end
`ifdef BTS_STATS_EN
      checks++; if (trap_cnt !== 16'd1) begin errors++; $display("[TB] FAIL trap_cnt got=%0d exp=1", trap_cnt); end
`endif
      set_flags(4'b0000);
      drive_issue(7'b1000001, 7'h05, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++; if (trap_req !== 1'b0) begin errors++; $display("[TB] FAIL trap_false cyc=%0d got=%b exp=0", i, trap_req); end
         checks++; if ((res_valid | bad_op) !== 1'b0) begin errors++; $display("[TB] FAIL trap_false_pulse cyc=%0d got=%b exp=0", i, res_valid | bad_op); end
      end
      drive_issue(7'b1001000, 7'h2A, 1'b0);
      tick;
      checks++; if (trap_tt !== 8'hAA) begin errors++; $display("[TB] FAIL trap_tt_ta got=%h exp=aa", trap_tt); end
      trap_ack = 1'b1;
      tick;
      trap_ack = 1'b0;
   endtask

   task automatic test_flush;
      drive_issue(7'b0001000, 7'h00, 1'b1);
      tick;
      flush   = 1'b1;
      cc_busy = 1'b0;
      tick;
      flush = 1'b0;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_wait_ready got=%b exp=1", issue_ready); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_wait_res got=%b exp=0", res_valid); end
      tick;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_wait_res_late got=%b exp=0", res_valid); end

      drive_issue(7'b1001000, 7'h11, 1'b0);
      tick;
      checks++; if (trap_req !== 1'b1) begin errors++; $display("[TB] FAIL flush_trap_setup got=%b exp=1", trap_req); end
      flush    = 1'b1;
      trap_ack = 1'b1;
      tick;
      flush    = 1'b0;
      trap_ack = 1'b0;
      checks++; if (trap_req !== 1'b0) begin errors++; $display("[TB] FAIL flush_trap_req got=%b exp=0", trap_req); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_trap_ready got=%b exp=1", issue_ready); end

      flush = 1'b1;
      drive_issue(7'b0001000, 7'h00, 1'b0);
      flush = 1'b0;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_issue_ready got=%b exp=1", issue_ready); end
      tick;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_issue_res got=%b exp=0", res_valid); end

      drive_issue(7'b0001000, 7'h00, 1'b0);
      flush = 1'b1;
      tick;
      flush = 1'b0;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_resolve_res got=%b exp=0", res_valid); end

      drive_issue(7'b0101000, 7'h00, 1'b0);
      checks++; if (bad_op !== 1'b0) begin errors++; $display("[TB] FAIL badop_early got=%b exp=0", bad_op); end
      tick;
      checks++; if (bad_op !== 1'b1) begin errors++; $display("[TB] FAIL badop_pulse got=%b exp=1", bad_op); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL badop_res got=%b exp=0", res_valid); end
      drive_issue(7'b1100001, 7'h00, 1'b0);
      checks++; if (bad_op !== 1'b0) begin errors++; $display("[TB] FAIL badop_width got=%b exp=0", bad_op); end
      tick;
      checks++; if (bad_op !== 1'b1) begin errors++; $display("[TB] FAIL badop11_pulse got=%b exp=1", bad_op); end

      drive_issue(7'b1001000, 7'h05, 1'b0);
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      checks++; if (trap_req !== 1'b0) begin errors++; $display("[TB] FAIL midreset_req got=%b exp=0", trap_req); end
      checks++; if (trap_tt !== 8'h00) begin errors++; $display("[TB] FAIL midreset_tt got=%h exp=00", trap_tt); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready got=%b exp=1", issue_ready); end
   endtask

   // Stream of branches with issue_valid held high, accepted whenever ready.
   task automatic test_back_to_back;
      logic [6:0] list[6] = '{7'b0000011, 7'b0001011, 7'b0000110, 7'b0011110, 7'b0011000, 7'b0010000};
      int   idx  = 0;
      int   pops = 0;
      logic acc;
      exp_t e;
      set_flags(4'b0100);
      cc_busy     = 1'b0;
      ir31_25     = list[0];
      issue_valid = 1'b1;
      for (int cyc = 0; cyc < 40 && (idx < 6 || sb.size() != 0); cyc++) begin
         acc = issue_valid && issue_ready;
         tick;
         if (res_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("[TB] FAIL b2b_unexpected got res_valid=1 exp=0");
            end else begin
               e = sb.pop_front();
               pops++;
               if ({br_taken, annul_slot} !== {e.taken, e.annul}) begin
                  errors++;
                  $display("[TB] FAIL b2b_result n=%0d got=%b%b exp=%b%b", pops, br_taken, annul_slot, e.taken, e.annul);
               end
            end
         end
         if (acc) begin
            sb.push_back(expect_br(list[idx], 4'b0100));
            idx++;
            if (idx < 6) ir31_25 = list[idx];
            else issue_valid = 1'b0;
         end
      end
      issue_valid = 1'b0;
      checks++;
      if (idx != 6 || sb.size() != 0 || pops != 6) begin
         errors++;
         $display("[TB] FAIL b2b_timeout got accepted=%0d results=%0d exp=6/6", idx, pops);
      end
   endtask

   initial begin
      test_reset;
      test_all_conds;
      test_annul;
      test_cc_busy;
      test_trap;
      test_flush;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
